// File: rtl/axil_master_bridge_pkg.sv
// Shared widths for the core-side memory bus and the transaction timer.
package axil_master_bridge_pkg;

    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_BUS      = 32;
    localparam int MEM_SEL      = MEM_BUS / 8;
    localparam int CNT_W        = 16;

endpackage

// File: rtl/axil_master_bridge.sv
// Bridges a simple req/ack core bus onto an AXI4-Lite master port.
// One transaction at a time; writes finish on AW+W handshakes (no B channel).
//
// state | meaning
// IDLE  | waiting for req_i; ack_o pulses here after a transaction
// WR    | AW and W presented, each dropped once its handshake is seen
// RA    | read address presented
// RD    | rready high, waiting for read data
module axil_master_bridge
    import axil_master_bridge_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [MEM_ADDR_BUS-1:0] addr_i,
    input  logic [MEM_BUS-1:0]      wdata_i,
    input  logic [MEM_SEL-1:0]      sel_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [MEM_BUS-1:0]      rdata_o,
    output logic [MEM_ADDR_BUS-1:0] m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [MEM_BUS-1:0]      m_axi_wdata,
    output logic [MEM_SEL-1:0]      m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [MEM_ADDR_BUS-1:0] m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [MEM_BUS-1:0]      m_axi_rdata,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RA   = 2'd2,
        RD   = 2'd3
    } state_t;

    // Last count value a transaction may reach before it is aborted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [MEM_ADDR_BUS-1:0] addr_q, addr_d;
    logic [MEM_BUS-1:0]      wdata_q, wdata_d;
    logic [MEM_SEL-1:0]      sel_q, sel_d;
    logic                    ack_d, err_d;
    logic [MEM_BUS-1:0]      rdata_d;
    logic                    aw_fire, w_fire, ar_fire, tmo_hit;

    // Valids come straight from registered state, so they drop the cycle
    // after a handshake or an abort and are low during reset.
    assign m_axi_awvalid = (state_q == WR) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR) && !w_done_q;
    assign m_axi_arvalid = (state_q == RA);
    assign m_axi_rready  = (state_q == RD);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = sel_q;

    assign aw_fire = m_axi_awvalid && m_axi_awready;
    assign w_fire  = m_axi_wvalid  && m_axi_wready;
    assign ar_fire = m_axi_arvalid && m_axi_arready;
    assign tmo_hit = (cnt_q == CNT_LAST);

    // Next-state, timer and completion logic; completion wins over timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_o;
        case (state_q)
            IDLE: begin
                if (req_i && !ack_o) begin
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    sel_d     = sel_i;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = we_i ? WR : RA;
                end
            end
            WR: begin
                cnt_d     = cnt_q + CNT_W'(1);
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RA: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An address accepted on the last allowed cycle cannot finish in time.
                if (tmo_hit) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (ar_fire) begin
                    state_d = RD;
                end
            end
            RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (m_axi_rvalid) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    rdata_d = m_axi_rdata;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            ack_o     <= ack_d;
            err_o     <= err_d;
            rdata_o   <= rdata_d;
        end
    end

endmodule
